acc_op_sequencer: RTL and testbench
===================================

Name: acc_op_sequencer

Overview:
Command-driven controller for the 8-bit accumulator register (Q/Data/LD/INC/CLR style). It accepts one register-reference operation at a time over a valid/ready handshake. It sequences the accumulator's LD/INC/CLR strobes, computes the load data (complement, shifts, add, and) from fed-back AC contents, owns the E (carry/link) flip-flop, and reports skip-test results. It sits between the control unit and the accumulator.

Parameters:
WIDTH, 8, accumulator and operand width; all arithmetic is modulo 2^WIDTH.
STATS_W, 16, width of the optional executed-command counter.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
CLR  in  1  reset; synchronous, active-high.
CMD_VALID  in  1  command offered.
CMD_READY  out  1  high only in IDLE; a command is accepted on the edge where CMD_VALID and CMD_READY are both 1.
CMD_OP  in  4  opcode, sampled at accept.
CMD_OPERAND  in  WIDTH  operand or count, sampled at accept.
AC_Q  in  WIDTH  current accumulator value, fed back from the register.
AC_LD  out  1  load strobe to the accumulator.
AC_INC  out  1  increment strobe.
AC_CLR  out  1  clear strobe.
AC_DATA  out  WIDTH  load data; valid while AC_LD=1, otherwise 0.
E  out  1  link/carry flag.
SKIP  out  1  skip-test result; valid while DONE=1, otherwise 0.
DONE  out  1  one-cycle completion pulse.
BUSY  out  1  high in EXEC and FIN.
OP_COUNT  out  STATS_W  executed-command count; only when the optional feature is enabled.

Behaviour:
- FSM states: IDLE -> EXEC -> FIN -> IDLE.
  - Accept moves IDLE to EXEC and latches op and operand; the count register is loaded with the operand.
  - FIN asserts DONE for exactly one cycle, then returns to IDLE.
- AC_LD, AC_INC, AC_CLR and AC_DATA are decoded combinationally from the latched op while in EXEC; they are 0 in every other state. At most one strobe is high in any cycle.
- Opcodes and their EXEC actions:
  - 0 NOP: no strobe.
  - 1 CLA: AC_CLR.
  - 2 CMA: AC_LD, data = ~AC_Q.
  - 3 INC: AC_INC; E unchanged.
  - 4 LDA: AC_LD, data = operand.
  - 5 ADD: AC_LD, data = (AC_Q + operand) mod 2^WIDTH; E <= carry out.
  - 6 AND: AC_LD, data = AC_Q & operand.
  - 7 CIR: AC_LD, data = {E, AC_Q[WIDTH-1:1]}; E <= AC_Q[0].
  - 8 CIL: AC_LD, data = {AC_Q[WIDTH-2:0], E}; E <= AC_Q[WIDTH-1].
  - 9 CLE: E <= 0.
  - 10 CME: E <= ~E.
  - 11 SZA: SKIP = (AC_Q == 0).
  - 12 SNA: SKIP = AC_Q[WIDTH-1].
  - 13 SZE: SKIP = (E == 0).
  - 14 INCN: increment the accumulator operand times.
  - 15: reserved; executes as NOP.
- Skip tests evaluate AC_Q and E during EXEC, register the result, and present SKIP during FIN.
- E is updated on the same edge that ends EXEC, i.e. the same edge on which the accumulator loads.
- Latency: every op except INCN occupies one EXEC cycle. Accept edge to DONE is 2 cycles, giving a throughput of 1 command per 3 cycles.
- INCN:
  - Remains in EXEC for max(N,1) cycles, where N = operand.
  - Asserts AC_INC in each cycle while count != 0 and decrements count each cycle.
  - N = 0: one EXEC cycle with no strobe.
  - AC wraps 0xFF -> 0x00 with no effect on E.
- CMD_VALID held high while BUSY is ignored; no queueing. CMD_OP and CMD_OPERAND may change freely after accept.
- Reset (CLR=1) has priority over everything, including mid-INCN:
  - State goes to IDLE, count = 0, E = 0, SKIP = 0, DONE = 0.
  - All strobes and AC_DATA are 0 in the reset cycle. The controller does not clear the accumulator itself.
  - CMD_READY = 1 in the first cycle after reset deasserts.
  - OP_COUNT = 0.

Optional Feature:
ACC_OP_SEQUENCER_STATS_EN:
- Defined: OP_COUNT increments by 1 on each DONE pulse, saturates at 2^STATS_W-1, and is cleared by CLR.
- Undefined: OP_COUNT is tied to 0 and no counter flops exist.

Test Plan:
- LDA 0x3C then ADD 0xD0 -> after the second DONE, AC = 0x0C and E = 1. One AC_LD per command; AC_DATA = 0x3C, then 0x0C.
- With E = 0, LDA 0x81 then CIL -> AC = 0x02, E = 1. Then CIR -> AC = 0x81, E = 0.
- LDA 0xFD then INCN 5 -> exactly 5 consecutive AC_INC cycles, BUSY for 6 cycles, AC = 0x02, E unchanged. INCN 0 -> no AC_INC, DONE 2 cycles after accept.
- CLA then SZA -> SKIP = 1 in the DONE cycle. INC then SZA -> SKIP = 0. CLE, SZE -> SKIP = 1.
- CMD_VALID held high continuously with alternating ops -> accepts spaced exactly 3 cycles apart; CMD_READY is never high while BUSY.
- CLR asserted in the 3rd cycle of INCN 10 -> only 2 AC_INC pulses issued, no DONE, E = 0, CMD_READY = 1 in the cycle after CLR drops. With STATS_EN, OP_COUNT = 0.

Source files
------------

// File: rtl/acc_op_sequencer.sv
// Register-reference op sequencer for an 8-bit accumulator: IDLE -> EXEC -> FIN handshake FSM.
// Optional executed-command counter enabled by defining ACC_OP_SEQUENCER_STATS_EN.
module acc_op_sequencer #(
   parameter int WIDTH   = 8,
   parameter int STATS_W = 16
) (
   input  logic               CLK,
   input  logic               CLR,
   input  logic               CMD_VALID,
   output logic               CMD_READY,
   input  logic [3:0]         CMD_OP,
   input  logic [WIDTH-1:0]   CMD_OPERAND,
   input  logic [WIDTH-1:0]   AC_Q,
   output logic               AC_LD,
   output logic               AC_INC,
   output logic               AC_CLR,
   output logic [WIDTH-1:0]   AC_DATA,
   output logic               E,
   output logic               SKIP,
   output logic               DONE,
   output logic               BUSY,
   output logic [STATS_W-1:0] OP_COUNT
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FIN} state_t;

   localparam logic [3:0] OP_CLA  = 4'd1,  OP_CMA = 4'd2,  OP_INC = 4'd3,  OP_LDA = 4'd4;
   localparam logic [3:0] OP_ADD  = 4'd5,  OP_AND = 4'd6,  OP_CIR = 4'd7,  OP_CIL = 4'd8;
   localparam logic [3:0] OP_CLE  = 4'd9,  OP_CME = 4'd10, OP_SZA = 4'd11, OP_SNA = 4'd12;
   localparam logic [3:0] OP_SZE  = 4'd13, OP_INCN = 4'd14;

   state_t           state_q, state_d;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             e_q, e_d;
   logic             skip_q, skip_d;
   logic [WIDTH:0]   sum;
   logic             ld, inc, clr;
   logic [WIDTH-1:0] data;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      e_d     = e_q;
      skip_d  = skip_q;
      ld      = 1'b0;
      inc     = 1'b0;
      clr     = 1'b0;
      data    = '0;
      sum     = {1'b0, AC_Q} + {1'b0, opnd_q};
      case (state_q)
         S_IDLE: begin
            if (CMD_VALID) begin
               state_d = S_EXEC;
               cnt_d   = CMD_OPERAND;
            end
         end
         S_EXEC: begin
            state_d = S_FIN;
            skip_d  = 1'b0;
            case (op_q)
               OP_CLA: clr = 1'b1;
               OP_CMA: begin ld = 1'b1; data = ~AC_Q; end
               OP_INC: inc = 1'b1;
               OP_LDA: begin ld = 1'b1; data = opnd_q; end
               OP_ADD: begin ld = 1'b1; data = sum[WIDTH-1:0]; e_d = sum[WIDTH]; end
               OP_AND: begin ld = 1'b1; data = AC_Q & opnd_q; end
               OP_CIR: begin ld = 1'b1; data = {e_q, AC_Q[WIDTH-1:1]}; e_d = AC_Q[0]; end
               OP_CIL: begin ld = 1'b1; data = {AC_Q[WIDTH-2:0], e_q}; e_d = AC_Q[WIDTH-1]; end
               OP_CLE: e_d = 1'b0;
               OP_CME: e_d = ~e_q;
               OP_SZA: skip_d = (AC_Q == '0);
               OP_SNA: skip_d = AC_Q[WIDTH-1];
               OP_SZE: skip_d = ~e_q;
               OP_INCN: begin
                  // count holds remaining increments; a zero count still spends one EXEC cycle
                  if (cnt_q != '0) begin
                     inc   = 1'b1;
                     cnt_d = cnt_q - 1'b1;
                  end
                  if (cnt_q > WIDTH'(1)) state_d = S_EXEC;
               end
               default: ;
            endcase
         end
         S_FIN: begin
            state_d = S_IDLE;
            skip_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
      if (CLR) begin
         ld   = 1'b0;
         inc  = 1'b0;
         clr  = 1'b0;
         data = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         e_q     <= 1'b0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         e_q     <= e_d;
         skip_q  <= skip_d;
      end
   end

   // Command payload is plain data; it is only consumed after a fresh accept
   always_ff @(posedge CLK) begin
      if (state_q == S_IDLE && CMD_VALID) begin
         op_q   <= CMD_OP;
         opnd_q <= CMD_OPERAND;
      end
   end

   assign CMD_READY = (state_q == S_IDLE) && !CLR;
   assign BUSY      = (state_q != S_IDLE);
   assign DONE      = (state_q == S_FIN) && !CLR;
   assign SKIP      = DONE && skip_q;
   assign E         = e_q;
   assign AC_LD     = ld;
   assign AC_INC    = inc;
   assign AC_CLR    = clr;
   assign AC_DATA   = data;

`ifdef ACC_OP_SEQUENCER_STATS_EN
   logic [STATS_W-1:0] opcnt_q;

   always_ff @(posedge CLK) begin
      if (CLR)                           opcnt_q <= '0;
      else if (DONE && (opcnt_q != '1))  opcnt_q <= opcnt_q + 1'b1;
   end

   assign OP_COUNT = opcnt_q;
`else
   assign OP_COUNT = '0;
`endif

endmodule

// File: tb/tb_acc_op_sequencer.sv
// Bench for acc_op_sequencer: directed plan plus random commands against an arithmetic
// reference model; a behavioural accumulator register closes the AC_Q feedback loop.
module tb_acc_op_sequencer;

   logic        CLK = 1'b0;
   logic        CLR;
   logic        CMD_VALID;
   logic        CMD_READY;
   logic [3:0]  CMD_OP;
   logic [7:0]  CMD_OPERAND;
   logic [7:0]  AC_Q;
   logic        AC_LD, AC_INC, AC_CLR;
   logic [7:0]  AC_DATA;
   logic        E, SKIP, DONE, BUSY;
   logic [15:0] OP_COUNT;

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_ac  = 0;
   int m_e   = 0;
   int m_ops = 0;

   logic [7:0] acc = 8'h00;

   always #5 CLK = ~CLK;

   acc_op_sequencer #(.WIDTH(8), .STATS_W(16)) dut (
      .CLK(CLK), .CLR(CLR), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_OP(CMD_OP), .CMD_OPERAND(CMD_OPERAND), .AC_Q(AC_Q),
      .AC_LD(AC_LD), .AC_INC(AC_INC), .AC_CLR(AC_CLR), .AC_DATA(AC_DATA),
      .E(E), .SKIP(SKIP), .DONE(DONE), .BUSY(BUSY), .OP_COUNT(OP_COUNT)
   );

   // accumulator register driven by the strobes
   always_ff @(posedge CLK) begin
      if (AC_CLR)      acc <= 8'h00;
      else if (AC_LD)  acc <= AC_DATA;
      else if (AC_INC) acc <= acc + 8'h01;
   end
   assign AC_Q = acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_opcount();
`ifdef ACC_OP_SEQUENCER_STATS_EN
      return m_ops;
`else
      return 0;
`endif
   endfunction

   // Applies one command to the model; returns expected skip, strobe counts, accept->DONE latency
   task automatic model(input int op, input int n, output int xskip, output int xld,
                        output int xinc, output int xclr, output int xlat);
      int s;
      int t;
      xskip = 0; xld = 0; xinc = 0; xclr = 0; xlat = 2;
      case (op)
         1:  begin m_ac = 0; xclr = 1; end
         2:  begin m_ac = 255 - m_ac; xld = 1; end
         3:  begin m_ac = (m_ac + 1) % 256; xinc = 1; end
         4:  begin m_ac = n; xld = 1; end
         5:  begin s = m_ac + n; m_ac = s % 256; m_e = s / 256; xld = 1; end
         6:  begin m_ac = m_ac & n; xld = 1; end
         7:  begin t = m_ac % 2; m_ac = m_ac / 2 + 128 * m_e; m_e = t; xld = 1; end
         8:  begin t = m_ac / 128; m_ac = (m_ac * 2) % 256 + m_e; m_e = t; xld = 1; end
         9:  m_e = 0;
         10: m_e = 1 - m_e;
         11: xskip = (m_ac == 0) ? 1 : 0;
         12: xskip = (m_ac >= 128) ? 1 : 0;
         13: xskip = (m_e == 0) ? 1 : 0;
         14: begin m_ac = (m_ac + n) % 256; xinc = n; xlat = ((n > 1) ? n : 1) + 1; end
         default: ;
      endcase
      if (m_ops < 65535) m_ops++;
   endtask

   task automatic run_cmd(input int op, input int n);
      int xskip, xld, xinc, xclr, xlat;
      int nld, ninc, nclr, lat, multi, dirty;
      logic [7:0] ldd;
      logic done_seen;
      logic skip_seen;
      @(negedge CLK);
      chk("opcount", 32'(OP_COUNT), 32'(exp_opcount()));
      chk("ready_idle", 32'(CMD_READY), 32'd1);
      model(op, n, xskip, xld, xinc, xclr, xlat);
      CMD_VALID   = 1'b1;
      CMD_OP      = 4'(op);
      CMD_OPERAND = 8'(n);
      @(posedge CLK);
      #1;
      CMD_VALID   = 1'b0;
      CMD_OP      = 4'($urandom_range(0, 15));
      CMD_OPERAND = 8'($urandom_range(0, 255));
      nld = 0; ninc = 0; nclr = 0; lat = 0; multi = 0; dirty = 0;
      ldd = 8'h00; done_seen = 1'b0; skip_seen = 1'b0;
      while (!done_seen && lat < 300) begin
         @(negedge CLK);
         lat++;
         nld  += int'(AC_LD);
         ninc += int'(AC_INC);
         nclr += int'(AC_CLR);
         if (int'(AC_LD) + int'(AC_INC) + int'(AC_CLR) > 1) multi++;
         if (AC_LD) ldd = AC_DATA;
         else if (AC_DATA != 8'h00) dirty++;
         if (CMD_READY || !BUSY) dirty++;
         if (DONE) begin
            done_seen = 1'b1;
            skip_seen = SKIP;
         end
      end
      chk($sformatf("done_seen op%0d", op), 32'(done_seen), 32'd1);
      chk($sformatf("latency op%0d", op), 32'(lat), 32'(xlat));
      chk($sformatf("n_ld op%0d", op), 32'(nld), 32'(xld));
      chk($sformatf("n_inc op%0d", op), 32'(ninc), 32'(xinc));
      chk($sformatf("n_clr op%0d", op), 32'(nclr), 32'(xclr));
      chk($sformatf("one_strobe op%0d", op), 32'(multi), 32'd0);
      chk($sformatf("idle_outs op%0d", op), 32'(dirty), 32'd0);
      if (xld != 0) chk($sformatf("ld_data op%0d", op), 32'(ldd), 32'(m_ac));
      chk($sformatf("skip op%0d", op), 32'(skip_seen), 32'(xskip));
      chk($sformatf("ac op%0d", op), 32'(acc), 32'(m_ac));
      chk($sformatf("e op%0d", op), 32'(E), 32'(m_e));
   endtask

   initial begin
      int tp_op[6];
      int tp_n[6];
      int t, prev, w, op, n, xs, xl, xi, xc, xt;

      CLR = 1'b1; CMD_VALID = 1'b0; CMD_OP = 4'd0; CMD_OPERAND = 8'd0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_strobes", 32'({AC_LD, AC_INC, AC_CLR}), 32'd0);
      chk("rst_data", 32'(AC_DATA), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_skip", 32'(SKIP), 32'd0);
      chk("rst_e", 32'(E), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_opcount", 32'(OP_COUNT), 32'd0);
      @(posedge CLK);
      #1 CLR = 1'b0;
      @(negedge CLK);
      chk("ready_after_rst", 32'(CMD_READY), 32'd1);

      // directed plan
      run_cmd(4, 8'h3C);  run_cmd(5, 8'hD0);
      run_cmd(9, 0);      run_cmd(4, 8'h81);  run_cmd(8, 0);  run_cmd(7, 0);
      run_cmd(4, 8'hFD);  run_cmd(14, 5);     run_cmd(14, 0);
      run_cmd(1, 0);      run_cmd(11, 0);
      run_cmd(3, 0);      run_cmd(11, 0);
      run_cmd(9, 0);      run_cmd(13, 0);
      run_cmd(2, 0);      run_cmd(12, 0);     run_cmd(6, 8'h5A); run_cmd(15, 8'h77);
      run_cmd(4, 8'hFE);  run_cmd(14, 3);

      // back-to-back with CMD_VALID held high
      tp_op = '{4, 10, 4, 10, 0, 10};
      for (int i = 0; i < 6; i++) tp_n[i] = int'($urandom_range(0, 255));
      @(negedge CLK);
      t = 0; prev = 0;
      CMD_VALID = 1'b1;
      for (int i = 0; i < 6; i++) begin
         CMD_OP = 4'(tp_op[i]);
         CMD_OPERAND = 8'(tp_n[i]);
         model(tp_op[i], tp_n[i], xs, xl, xi, xc, xt);
         w = 0;
         while (!CMD_READY && w < 10) begin
            chk("ready_vs_busy", 32'(CMD_READY & BUSY), 32'd0);
            @(negedge CLK);
            t++; w++;
         end
         chk("ready_vs_busy", 32'(CMD_READY & BUSY), 32'd0);
         if (i > 0) chk($sformatf("accept_gap %0d", i), 32'(t - prev), 32'd3);
         prev = t;
         @(negedge CLK);
         t++;
      end
      CMD_VALID = 1'b0;
      repeat (3) @(negedge CLK);
      chk("tp_ac", 32'(acc), 32'(m_ac));
      chk("tp_e", 32'(E), 32'(m_e));

      // random commands
      for (int i = 0; i < 40; i++) begin
         op = int'($urandom_range(0, 15));
         n  = (op == 14) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 255));
         run_cmd(op, n);
      end

      // reset in the third EXEC cycle of INCN 10
      run_cmd(9, 0); run_cmd(10, 0); run_cmd(4, 8'h10);
      @(negedge CLK);
      CMD_VALID = 1'b1; CMD_OP = 4'd14; CMD_OPERAND = 8'd10;
      @(posedge CLK);
      #1 CMD_VALID = 1'b0;
      @(negedge CLK);
      chk("incn_rst inc1", 32'(AC_INC), 32'd1);
      @(negedge CLK);
      chk("incn_rst inc2", 32'(AC_INC), 32'd1);
      @(posedge CLK);
      #1 CLR = 1'b1;
      @(negedge CLK);
      chk("incn_rst strobes", 32'({AC_LD, AC_INC, AC_CLR}), 32'd0);
      chk("incn_rst data", 32'(AC_DATA), 32'd0);
      chk("incn_rst done", 32'(DONE), 32'd0);
      @(posedge CLK);
      #1 CLR = 1'b0;
      m_ac = (m_ac + 2) % 256; m_e = 0; m_ops = 0;
      @(negedge CLK);
      chk("incn_rst ready", 32'(CMD_READY), 32'd1);
      chk("incn_rst busy", 32'(BUSY), 32'd0);
      chk("incn_rst e", 32'(E), 32'd0);
      chk("incn_rst ac", 32'(acc), 32'(m_ac));
      chk("incn_rst opcount", 32'(OP_COUNT), 32'd0);
      run_cmd(14, 2);
      run_cmd(11, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
